// File: rtl/fetch_sequencer_if.sv
// Program-memory and processor-issue bus between fetch_sequencer and its neighbours.
interface fetch_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] MemAddr;
   logic              MemRd;
   logic [8:0]        MemData;
   logic [8:0]        Din;
   logic              Run;
   logic              Done;

   modport master (
      output MemAddr, MemRd, Din, Run,
      input  MemData, Done
   );

   modport slave (
      input  MemAddr, MemRd, Din, Run,
      output MemData, Done
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller for the 9-bit multicycle processor.
// Fetches one word, issues it with Run in the processor's T0, keeps the
// following word on Din for immediate opcodes, and retires on Done.
module fetch_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned START_PC = 0,
   parameter int unsigned TIMEOUT  = 8
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   fetch_sequencer_if.master bus,
   output logic              Busy,
   output logic              Halted,
   output logic              Error,
   output logic [ADDR_W-1:0] PC,
   output logic [15:0]       InstrCount
);

   localparam int unsigned       CNT_W        = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] START_ADDR   = ADDR_W'(START_PC);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [2:0]        OP_MVI       = 3'b001;
   localparam logic [2:0]        OP_ADDI      = 3'b100;
   localparam logic [2:0]        OP_MVIALL    = 3'b101;
   localparam logic [2:0]        OP_HALT      = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [2:0]        mem_op;
   logic              imm_op;
   logic [ADDR_W-1:0] pc_inc1;
   logic [ADDR_W-1:0] pc_inc2;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [8:0]        din;
   logic              run;

   assign mem_op  = bus.MemData[8:6];
   assign imm_op  = (op_q == OP_MVI) || (op_q == OP_ADDI) || (op_q == OP_MVIALL);
   assign pc_inc1 = PC + ADDR_W'(1);
   assign pc_inc2 = PC + ADDR_W'(2);

   // Sequencer state, PC, retire counter and EXEC watchdog.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= S_IDLE;
         PC         <= START_ADDR;
         InstrCount <= 16'd0;
         op_q       <= 3'd0;
         tmo_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALTED: begin
               if (Start) begin
                  PC    <= START_ADDR;
                  state <= S_FETCH;
               end
            end
            S_FETCH: state <= S_ISSUE;
            S_ISSUE: begin
               if (mem_op == OP_HALT) begin
                  state <= S_HALTED;
               end else begin
                  op_q    <= mem_op;
                  tmo_cnt <= '0;
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (bus.Done) begin
                  PC         <= imm_op ? pc_inc2 : pc_inc1;
                  InstrCount <= InstrCount + 16'd1;
                  state      <= S_FETCH;
               end else if (tmo_cnt == TIMEOUT_LAST) begin
                  state <= S_ERROR;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            S_ERROR: state <= S_ERROR;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bus drive decoded from state; ISSUE/EXEC pass the synchronous-read data straight through.
   always_comb begin
      mem_addr = '0;
      mem_rd   = 1'b0;
      din      = 9'd0;
      run      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_addr = PC;
            mem_rd   = 1'b1;
         end
         S_ISSUE: begin
            if (mem_op != OP_HALT) begin
               din      = bus.MemData;
               run      = 1'b1;
               mem_addr = pc_inc1;
               mem_rd   = 1'b1;
            end
         end
         S_EXEC: begin
            mem_addr = pc_inc1;
            mem_rd   = 1'b1;
            din      = imm_op ? bus.MemData : 9'd0;
         end
         default: ;
      endcase
   end

   assign bus.MemAddr = mem_addr;
   assign bus.MemRd   = mem_rd;
   assign bus.Din     = din;
   assign bus.Run     = run;

   assign Busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_EXEC);
   assign Halted = (state == S_HALTED);
   assign Error  = (state == S_ERROR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: main DUT driving a small processor model, plus a 2-bit-address DUT for PC wrap.
module tb_fetch_sequencer;

   logic Clock  = 1'b0;
   logic Resetn = 1'b0;
   logic Start  = 1'b0;
   logic Start2 = 1'b0;
   logic stub_hold = 1'b0;

   logic       busy, halted, error;
   logic [7:0] pc;
   logic [15:0] icount;
   logic       busy2, halted2, error2;
   logic [1:0] pc2;
   logic [15:0] icount2;

   int vectors    = 0;
   int miscompares = 0;

   fetch_sequencer_if #(.ADDR_W(8)) bus1 ();
   fetch_sequencer_if #(.ADDR_W(2)) bus2 ();

   fetch_sequencer #(.ADDR_W(8), .START_PC(0), .TIMEOUT(8)) dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .bus(bus1),
      .Busy(busy), .Halted(halted), .Error(error), .PC(pc), .InstrCount(icount)
   );

   fetch_sequencer #(.ADDR_W(2), .START_PC(3), .TIMEOUT(8)) dut2 (
      .Clock(Clock), .Resetn(Resetn), .Start(Start2), .bus(bus2),
      .Busy(busy2), .Halted(halted2), .Error(error2), .PC(pc2), .InstrCount(icount2)
   );

   always #5 Clock = ~Clock;

   // Synchronous-read program memories
   logic [8:0] mem1 [0:255];
   logic [8:0] mem2 [0:3];
   always_ff @(posedge Clock) begin
      if (bus1.MemRd) bus1.MemData <= mem1[bus1.MemAddr];
      if (bus2.MemRd) bus2.MemData <= mem2[bus2.MemAddr];
   end

   // Processor model: T0 captures on Run, Done in T1 (MV/MVI/MVIALL/110) or T3 (ADD/SUB/ADDI)
   logic [8:0] regs [0:7];
   logic [1:0] p_t;
   logic [2:0] p_op, p_x, p_y;
   logic [8:0] p_a;
   logic       p_done;

   always_comb begin
      p_done = 1'b0;
      if (!stub_hold) begin
         if (p_t == 2'd1 && (p_op == 3'd0 || p_op == 3'd1 || p_op == 3'd5 || p_op == 3'd6))
            p_done = 1'b1;
         if (p_t == 2'd3)
            p_done = 1'b1;
      end
   end
   assign bus1.Done = p_done;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         p_t  <= 2'd0;
         p_op <= 3'd0;
         p_x  <= 3'd0;
         p_y  <= 3'd0;
         p_a  <= 9'd0;
         for (int i = 0; i < 8; i++) regs[i] <= 9'd0;
      end else begin
         case (p_t)
            2'd0: if (bus1.Run) begin
               p_op <= bus1.Din[8:6];
               p_x  <= bus1.Din[5:3];
               p_y  <= bus1.Din[2:0];
               p_t  <= 2'd1;
            end
            2'd1: if (p_done) begin
               case (p_op)
                  3'd0: regs[p_x] <= regs[p_y];
                  3'd1: regs[p_x] <= bus1.Din;
                  3'd5: for (int i = 0; i < 8; i++) regs[i] <= bus1.Din;
                  default: ;
               endcase
               p_t <= 2'd0;
            end else if (!stub_hold) begin
               p_a <= regs[p_x];
               p_t <= 2'd2;
            end
            2'd2: begin
               if (p_op == 3'd3) p_a <= p_a - regs[p_y];
               else if (p_op == 3'd4) p_a <= p_a + bus1.Din;
               else p_a <= p_a + regs[p_y];
               p_t <= 2'd3;
            end
            default: begin
               regs[p_x] <= p_a;
               p_t <= 2'd0;
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      bus2.Done = 1'b0;
      for (int i = 0; i < 256; i++) mem1[i] = 9'b111000000;
      for (int i = 0; i < 4; i++) mem2[i] = 9'b111000000;

      // Reset state
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_run", 32'(bus1.Run), 32'd0);
      check("rst_memrd", 32'(bus1.MemRd), 32'd0);
      check("rst_din", 32'(bus1.Din), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_icount", 32'(icount), 32'd0);
      check("rst_pc2", 32'(pc2), 32'd3);

      // Program 1: MVI R0,5 ; HALT
      mem1[0] = 9'b001000000; mem1[1] = 9'b000000101; mem1[2] = 9'b111000000;
      @(negedge Clock);
      Resetn = 1'b1;
      Start  = 1'b1;
      tick();                                          // cycle 1: FETCH
      Start = 1'b0;
      check("p1_fetch_rd", 32'(bus1.MemRd), 32'd1);
      check("p1_fetch_addr", 32'(bus1.MemAddr), 32'd0);
      check("p1_fetch_run", 32'(bus1.Run), 32'd0);
      check("p1_fetch_busy", 32'(busy), 32'd1);
      tick();                                          // cycle 2: ISSUE
      check("p1_issue_run", 32'(bus1.Run), 32'd1);
      check("p1_issue_din", 32'(bus1.Din), 32'h040);
      check("p1_issue_addr", 32'(bus1.MemAddr), 32'd1);
      tick();                                          // cycle 3: EXEC
      check("p1_exec_din", 32'(bus1.Din), 32'd5);
      check("p1_exec_run", 32'(bus1.Run), 32'd0);
      tick();                                          // cycle 4: FETCH of HALT
      check("p1_pc_after", 32'(pc), 32'd2);
      check("p1_icount", 32'(icount), 32'd1);
      tick();                                          // cycle 5: ISSUE of HALT
      check("p1_halt_run", 32'(bus1.Run), 32'd0);
      tick();                                          // cycle 6: HALTED
      check("p1_halted", 32'(halted), 32'd1);
      check("p1_halt_busy", 32'(busy), 32'd0);
      check("p1_halt_pc", 32'(pc), 32'd2);
      check("p1_r0", 32'(regs[0]), 32'd5);

      // Program 2: MVI R0,3 ; MVI R1,4 ; ADD R0,R1 ; HALT (restart from HALTED keeps count)
      mem1[0] = 9'b001000000; mem1[1] = 9'd3;
      mem1[2] = 9'b001001000; mem1[3] = 9'd4;
      mem1[4] = 9'b010000001; mem1[5] = 9'b111000000;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      n = 1;
      while (!halted && n < 40) begin
         tick();
         n++;
      end
      check("p2_cycles", 32'(n), 32'd14);              // 3+3+5+2 busy cycles, then HALTED
      check("p2_r0", 32'(regs[0]), 32'd7);
      check("p2_pc", 32'(pc), 32'd5);
      check("p2_icount", 32'(icount), 32'd4);          // 1 from program 1 + 3

      // Program 3: MVI R0,9 ; ADDI R0,2 ; HALT
      mem1[0] = 9'b001000000; mem1[1] = 9'd9;
      mem1[2] = 9'b100000000; mem1[3] = 9'd2; mem1[4] = 9'b111000000;
      Start = 1'b1;
      tick();                                          // FETCH MVI
      Start = 1'b0;
      tick(); tick(); tick();                          // ISSUE, EXEC, FETCH ADDI
      check("p3_pc_addi", 32'(pc), 32'd2);
      tick();                                          // ISSUE ADDI
      check("p3_issue_din", 32'(bus1.Din), 32'h100);
      tick();                                          // EXEC T1
      check("p3_imm_t1", 32'(bus1.Din), 32'd2);
      tick();                                          // EXEC T2
      check("p3_imm_t2", 32'(bus1.Din), 32'd2);
      tick();                                          // EXEC T3
      check("p3_t3_busy", 32'(busy), 32'd1);
      tick();                                          // FETCH HALT
      check("p3_pc_after", 32'(pc), 32'd4);
      tick(); tick();
      check("p3_halted", 32'(halted), 32'd1);
      check("p3_r0", 32'(regs[0]), 32'd11);
      check("p3_icount", 32'(icount), 32'd6);

      // Program 4: Start ignored in EXEC, then async reset mid-ADD
      mem1[0] = 9'b010000001; mem1[1] = 9'b111000000;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick();                                  // ISSUE, EXEC T1
      Start = 1'b1;
      tick();                                          // EXEC T2
      Start = 1'b0;
      check("p4_start_ign_busy", 32'(busy), 32'd1);
      check("p4_start_ign_addr", 32'(bus1.MemAddr), 32'd1);
      Resetn = 1'b0;
      #1;
      check("p4_rst_run", 32'(bus1.Run), 32'd0);
      check("p4_rst_memrd", 32'(bus1.MemRd), 32'd0);
      check("p4_rst_pc", 32'(pc), 32'd0);
      check("p4_rst_icount", 32'(icount), 32'd0);
      check("p4_rst_busy", 32'(busy), 32'd0);

      // Timeout: MVI with Done held low by the stub
      mem1[0] = 9'b001000000; mem1[1] = 9'd7;
      stub_hold = 1'b1;
      @(negedge Clock);
      Resetn = 1'b1;
      Start  = 1'b1;
      tick();                                          // FETCH
      Start = 1'b0;
      tick();                                          // ISSUE
      for (int i = 0; i < 8; i++) tick();              // EXEC cycles 1..8
      check("to_exec8_err", 32'(error), 32'd0);
      check("to_exec8_busy", 32'(busy), 32'd1);
      tick();
      check("to_error", 32'(error), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_din", 32'(bus1.Din), 32'd0);
      check("to_run", 32'(bus1.Run), 32'd0);
      Start = 1'b1;
      tick(); tick();
      Start = 1'b0;
      check("to_start_ign", 32'(error), 32'd1);
      check("to_start_memrd", 32'(bus1.MemRd), 32'd0);
      Resetn = 1'b0;
      #1;
      check("to_rst_err", 32'(error), 32'd0);
      stub_hold = 1'b0;

      // Wrap: ADDR_W=2, START_PC=3, MVI at 3, immediate at 0; Done held high from FETCH
      mem2[3] = 9'b001000000; mem2[0] = 9'b000000110; mem2[1] = 9'b111000000;
      @(negedge Clock);
      Resetn = 1'b1;
      Start2 = 1'b1;
      bus2.Done = 1'b1;
      tick();                                          // FETCH
      Start2 = 1'b0;
      check("wr_fetch_addr", 32'(bus2.MemAddr), 32'd3);
      tick();                                          // ISSUE (Done ignored so far)
      check("wr_issue_run", 32'(bus2.Run), 32'd1);
      check("wr_issue_addr", 32'(bus2.MemAddr), 32'd0);
      tick();                                          // EXEC
      check("wr_exec_din", 32'(bus2.Din), 32'h006);
      tick();                                          // FETCH at wrapped PC
      bus2.Done = 1'b0;
      check("wr_pc", 32'(pc2), 32'd1);
      check("wr_icount", 32'(icount2), 32'd1);
      check("wr_fetch2_addr", 32'(bus2.MemAddr), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
